// File: rtl/accel_avg_multi.sv
// Multi-channel boxcar moving-average filter for accelerometer samples.
// One shared add/subtract datapath visits the channels in turn.
// Ports:
//   clk_i            system clock
//   rst_i            synchronous reset, active-high
//   sample_valid_i   one-cycle strobe, sample_data_i valid this cycle
//   sample_data_i    packed samples, channel k at [k*DATA_W +: DATA_W]
//   clear_overrun_i  clears the sticky overrun flag
//   filtered_data_o  packed averages, same packing as sample_data_i
//   filtered_valid_o one-cycle strobe, new data while primed
//   primed_o         high once TAPS sets have been accepted
//   busy_o           high while a sample set is in flight
//   overrun_o        sticky: a strobe was dropped while busy
module accel_avg_multi #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 16,
  parameter int TAPS   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sample_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] sample_data_i,
  input  logic                     clear_overrun_i,
  output logic [NUM_CH*DATA_W-1:0] filtered_data_o,
  output logic                     filtered_valid_o,
  output logic                     primed_o,
  output logic                     busy_o,
  output logic                     overrun_o
);

  localparam int SH    = $clog2(TAPS);
  localparam int SUM_W = DATA_W + SH;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = SH + 1;

  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAPS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROC,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CH_W-1:0]  ch_q, ch_d;
  logic [SH-1:0]    wr_ptr_q;
  logic [CNT_W-1:0] fill_q;
  logic [CNT_W-1:0] fill_nxt;

  logic [DATA_W-1:0]       cap_q  [NUM_CH];
  logic [DATA_W-1:0]       hist_q [NUM_CH][TAPS];
  logic signed [SUM_W-1:0] sum_q  [NUM_CH];
  logic [DATA_W-1:0]       avg    [NUM_CH];

  logic [NUM_CH*DATA_W-1:0] fd_q;
  logic fv_q;
  logic primed_q;
  logic ovr_q;

  logic accept;
  logic drop;
  logic busy;

  logic [DATA_W-1:0]       new_s;
  logic [DATA_W-1:0]       old_s;
  logic signed [SUM_W-1:0] new_ext;
  logic signed [SUM_W-1:0] old_ext;

  assign busy = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sample_valid_i) begin
          accept  = 1'b1;
          ch_d    = '0;
          state_d = S_PROC;
        end
      end
      S_PROC: begin
        if (ch_q == LAST_CH) begin
          state_d = S_DONE;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A strobe arriving mid-set is discarded, never queued.
  assign drop = sample_valid_i && busy;

  assign new_s   = cap_q[ch_q];
  assign old_s   = hist_q[ch_q][wr_ptr_q];
  assign new_ext = {{SH{new_s[DATA_W-1]}}, new_s};
  assign old_ext = {{SH{old_s[DATA_W-1]}}, old_s};

  assign fill_nxt = (fill_q == FULL_CNT) ? fill_q : fill_q + 1'b1;

  // Arithmetic shift floors toward -inf.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      avg[k] = DATA_W'(sum_q[k] >>> SH);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      fd_q     <= '0;
      fv_q     <= 1'b0;
      primed_q <= 1'b0;
      ovr_q    <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        cap_q[k] <= '0;
        sum_q[k] <= '0;
        for (int t = 0; t < TAPS; t++) begin
          hist_q[k][t] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      fv_q    <= 1'b0;

      if (accept) begin
        for (int k = 0; k < NUM_CH; k++) begin
          cap_q[k] <= sample_data_i[k*DATA_W +: DATA_W];
        end
      end

      if (state_q == S_PROC) begin
        sum_q[ch_q] <= sum_q[ch_q] + new_ext - old_ext;
        hist_q[ch_q][wr_ptr_q] <= new_s;
      end

      if (state_q == S_DONE) begin
        // TAPS is a power of two, so the pointer wraps naturally.
        wr_ptr_q <= wr_ptr_q + 1'b1;
        fill_q   <= fill_nxt;
        for (int k = 0; k < NUM_CH; k++) begin
          fd_q[k*DATA_W +: DATA_W] <= avg[k];
        end
        if (fill_nxt == FULL_CNT) begin
          fv_q     <= 1'b1;
          primed_q <= 1'b1;
        end
      end

      // Set beats clear.
      if (drop) begin
        ovr_q <= 1'b1;
      end else if (clear_overrun_i) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign filtered_data_o  = fd_q;
  assign filtered_valid_o = fv_q;
  assign primed_o         = primed_q;
  assign busy_o           = busy;
  assign overrun_o        = ovr_q;

endmodule

// File: tb/tb_accel_avg_multi.sv
// Directed self-checking bench for accel_avg_multi.
// Default parameters: NUM_CH=3, DATA_W=16, TAPS=8.
module tb_accel_avg_multi;

  localparam int W = 48;

  logic         clk;
  logic         rst;
  logic         sample_valid;
  logic [W-1:0] sample_data;
  logic         clear_overrun;
  logic [W-1:0] filtered_data;
  logic         filtered_valid;
  logic         primed;
  logic         busy;
  logic         overrun;

  int n_checks;
  int n_err;

  accel_avg_multi dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .sample_valid_i   (sample_valid),
    .sample_data_i    (sample_data),
    .clear_overrun_i  (clear_overrun),
    .filtered_data_o  (filtered_data),
    .filtered_valid_o (filtered_valid),
    .primed_o         (primed),
    .busy_o           (busy),
    .overrun_o        (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rep3(input logic [15:0] v);
    return {v, v, v};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One strobe, then 9 more cycles observed; sample_data is
  // scrambled after acceptance to prove the capture register.
  task automatic send(input  logic [W-1:0] d,
                      output int           nv,
                      output int           vcyc,
                      output logic [W-1:0] vdata,
                      output logic [9:0]   bmask);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = d;
    nv    = 0;
    vcyc  = 0;
    vdata = '0;
    bmask = '0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) begin
        sample_valid = 1'b0;
        sample_data  = ~d;
      end
      if (filtered_valid === 1'b1) begin
        nv++;
        vcyc  = i;
        vdata = filtered_data;
      end
      bmask[i] = busy;
    end
  endtask

  int           nv, vcyc, tot;
  logic [W-1:0] vdata;
  logic [9:0]   bm;

  initial begin
    n_checks      = 0;
    n_err         = 0;
    rst           = 1'b1;
    sample_valid  = 1'b0;
    sample_data   = '0;
    clear_overrun = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_data", filtered_data, '0);
    chk("rst_valid", filtered_valid, 0);
    chk("rst_primed", primed, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);

    // Constant 0x0100 warm-up
    tot = 0;
    for (int s = 1; s <= 7; s++) begin
      send(rep3(16'h0100), nv, vcyc, vdata, bm);
      tot += nv;
      if (s == 1) begin
        chk("warm_partial", filtered_data, rep3(16'h0020));
        chk("busy_window", bm, 10'b0000011110);
      end
    end
    chk("warm_no_valid", tot, 0);
    chk("warm_not_primed", primed, 0);
    send(rep3(16'h0100), nv, vcyc, vdata, bm);
    chk("const_nv", nv, 1);
    chk("const_latency", vcyc, 5);
    chk("const_data", vdata, rep3(16'h0100));
    chk("const_primed", primed, 1);

    // Sign handling at extremes
    tot = 0;
    for (int s = 0; s < 8; s++) begin
      send({16'h8000, 16'h7FFF, 16'hFF00}, nv, vcyc, vdata, bm);
      tot += nv;
    end
    chk("sign_nv", tot, 8);
    chk("sign_data", vdata, {16'h8000, 16'h7FFF, 16'hFF00});

    // Step and pointer wrap
    for (int s = 0; s < 8; s++) send(rep3(16'h0000), nv, vcyc, vdata, bm);
    chk("step_zero", vdata, rep3(16'h0000));
    send(rep3(16'h0320), nv, vcyc, vdata, bm);
    chk("step_1", vdata, rep3(16'h0064));
    for (int s = 0; s < 3; s++) send(rep3(16'h0320), nv, vcyc, vdata, bm);
    chk("step_4", vdata, rep3(16'h0190));
    for (int s = 0; s < 4; s++) send(rep3(16'h0320), nv, vcyc, vdata, bm);
    chk("step_8", vdata, rep3(16'h0320));
    tot = 0;
    for (int s = 0; s < 20; s++) begin
      send(rep3(16'h0320), nv, vcyc, vdata, bm);
      tot += nv;
    end
    chk("wrap_nv", tot, 20);
    chk("wrap_data", vdata, rep3(16'h0320));

    // Truncation toward -inf from fresh reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tot = 0;
    for (int s = 0; s < 7; s++) begin
      send(rep3(16'h0000), nv, vcyc, vdata, bm);
      tot += nv;
    end
    chk("trunc_warm_nv", tot, 0);
    send({16'h0008, 16'hFFF7, 16'hFFFF}, nv, vcyc, vdata, bm);
    chk("trunc_nv", nv, 1);
    chk("trunc_data", vdata, {16'h0001, 16'hFFFE, 16'hFFFF});

    // Overrun: second strobe two cycles after the first
    for (int s = 0; s < 8; s++) send(rep3(16'h0000), nv, vcyc, vdata, bm);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = rep3(16'h0080);
    nv = 0;
    vcyc = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      sample_valid = (i == 2);
      if (i == 2) sample_data = rep3(16'h7F00);
      if (i == 3) chk("ovr_set", overrun, 1);
      if (filtered_valid === 1'b1) begin
        nv++;
        vcyc  = i;
        vdata = filtered_data;
      end
    end
    chk("ovr_first_nv", nv, 1);
    chk("ovr_first_lat", vcyc, 5);
    chk("ovr_first_data", vdata, rep3(16'h0010));
    send(rep3(16'h0000), nv, vcyc, vdata, bm);
    chk("ovr_state_kept", vdata, rep3(16'h0010));
    chk("ovr_sticky", overrun, 1);
    @(negedge clk);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    chk("ovr_clear", overrun, 0);

    // Drop and clear in the same cycle
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = rep3(16'h0000);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      sample_valid  = (i == 2);
      clear_overrun = (i == 2);
    end
    chk("ovr_set_wins", overrun, 1);
    @(negedge clk);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    chk("ovr_clear2", overrun, 0);

    // Reset while processing channel 1
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = rep3(16'h0040);
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    chk("midrst_busy_pre", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_data", filtered_data, '0);
    chk("midrst_valid", filtered_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_primed", primed, 0);
    chk("midrst_overrun", overrun, 0);
    tot = 0;
    for (int s = 0; s < 7; s++) begin
      send(rep3(16'h0040), nv, vcyc, vdata, bm);
      tot += nv;
    end
    chk("midrst_warm_nv", tot, 0);
    send(rep3(16'h0040), nv, vcyc, vdata, bm);
    chk("midrst_nv", nv, 1);
    chk("midrst_lat", vcyc, 5);
    chk("midrst_data8", vdata, rep3(16'h0040));

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
